bip_fetch_control: RTL and testbench



---
 rtl/bip_fetch_control.sv | 122 ++++++++++++
 tb/tb_bip_fetch_control.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_fetch_control.sv
// BIP fetch/run control: program counter, opcode/operand split, IDLE/RUN/HALT FSM, cycle counter.
// Optional build macro BIP_STEP_MODE_EN adds a step input that gates instruction execution in RUN.
module bip_fetch_control #(
  parameter int PC_W  = 11,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef BIP_STEP_MODE_EN
  input  logic             step,
`endif
  input  logic [15:0]      Instr_in,
  input  logic             WrPC,
  output logic [PC_W-1:0]  Addr_pm,
  output logic [4:0]       Opcode,
  output logic [10:0]      Operand,
  output logic             running,
  output logic             halted,
  output logic             done,
  output logic             pc_ovf,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [PC_W-1:0]  PC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc, pc_next;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;
  logic             exec;

  // Control protocol: start is a one-cycle request honoured only in IDLE/HALT;
  // WrPC is sampled only in executing RUN cycles (1 = advance, 0 = HALT executed).
`ifdef BIP_STEP_MODE_EN
  assign exec = (state == RUN) && step;
`else
  assign exec = (state == RUN);
`endif

  assign Addr_pm = pc;

  // Non-executing cycles present a zero opcode so the decoder deasserts all writes.
  always_comb begin
    Opcode  = '0;
    Operand = '0;
    if (exec) begin
      Opcode  = Instr_in[15:11];
      Operand = Instr_in[10:0];
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    cnt_next   = cycle_count;
    ovf_next   = pc_ovf;
    case (state)
      IDLE: begin
        pc_next = '0;
        if (start) begin
          state_next = RUN;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      RUN: begin
        if (exec) begin
          if (cycle_count != CNT_MAX) begin
            cnt_next = cycle_count + CNT_W'(1);
          end
          if (!WrPC) begin
            state_next = HALT;
          end else if (pc == PC_MAX) begin
            // End of program memory: hold PC rather than wrap.
            ovf_next   = 1'b1;
            state_next = HALT;
          end else begin
            pc_next = pc + PC_W'(1);
          end
        end
      end
      HALT: begin
        if (start) begin
          state_next = RUN;
          pc_next    = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
      pc_ovf      <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      cycle_count <= cnt_next;
      pc_ovf      <= ovf_next;
      running     <= (state_next == RUN);
      halted      <= (state_next == HALT);
      done        <= (state_next == HALT) && (state != HALT);
    end
  end

endmodule

// File: tb/tb_bip_fetch_control.sv
// Bench for bip_fetch_control: three instances (default, PC_W=3, PC_W=4/CNT_W=3) share one program memory.
// Expected behaviour comes from whole-program analysis (first HALT index, run length, saturation).
module tb_bip_fetch_control;

  localparam int N = 3;
`ifdef BIP_STEP_MODE_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, step_v;
  logic [15:0] mem [0:2047];

  logic [10:0] addr_a;  logic [2:0] addr_b;  logic [3:0] addr_c;
  logic [4:0]  op_a, op_b, op_c;
  logic [10:0] opd_a, opd_b, opd_c;
  logic        run_a, run_b, run_c, hlt_a, hlt_b, hlt_c;
  logic        dn_a, dn_b, dn_c, ovf_a, ovf_b, ovf_c;
  logic [15:0] cnt_a, cnt_b;  logic [2:0] cnt_c;
  logic [15:0] instr_a, instr_b, instr_c;
  logic        wrpc_a, wrpc_b, wrpc_c;

  int n_checks = 0;
  int n_errors = 0;

  initial forever #5 clk = ~clk;

  // Memory and decoder stand-in: HALT is opcode 00000, anything else advances the PC.
  assign instr_a = mem[addr_a];
  assign instr_b = mem[{8'd0, addr_b}];
  assign instr_c = mem[{7'd0, addr_c}];
  assign wrpc_a  = (instr_a[15:11] != 5'd0);
  assign wrpc_b  = (instr_b[15:11] != 5'd0);
  assign wrpc_c  = (instr_c[15:11] != 5'd0);

  bip_fetch_control u_a (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BIP_STEP_MODE_EN
    .step(step_v),
`endif
    .Instr_in(instr_a), .WrPC(wrpc_a), .Addr_pm(addr_a), .Opcode(op_a), .Operand(opd_a),
    .running(run_a), .halted(hlt_a), .done(dn_a), .pc_ovf(ovf_a), .cycle_count(cnt_a));

  bip_fetch_control #(.PC_W(3), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BIP_STEP_MODE_EN
    .step(step_v),
`endif
    .Instr_in(instr_b), .WrPC(wrpc_b), .Addr_pm(addr_b), .Opcode(op_b), .Operand(opd_b),
    .running(run_b), .halted(hlt_b), .done(dn_b), .pc_ovf(ovf_b), .cycle_count(cnt_b));

  bip_fetch_control #(.PC_W(4), .CNT_W(3)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BIP_STEP_MODE_EN
    .step(step_v),
`endif
    .Instr_in(instr_c), .WrPC(wrpc_c), .Addr_pm(addr_c), .Opcode(op_c), .Operand(opd_c),
    .running(run_c), .halted(hlt_c), .done(dn_c), .pc_ovf(ovf_c), .cycle_count(cnt_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pcw(input int i);
    return (i == 0) ? 11 : (i == 1) ? 3 : 4;
  endfunction

  function automatic int cntw(input int i);
    return (i == 2) ? 3 : 16;
  endfunction

  function automatic int sat(input int i, input int v);
    int m;
    m = (1 << cntw(i)) - 1;
    return (v > m) ? m : v;
  endfunction

  // Instructions executed before stopping: up to and including the first HALT, else the whole memory.
  function automatic int run_len(input int i);
    int lim;
    lim = 1 << pcw(i);
    for (int j = 0; j < lim; j++) begin
      if (mem[j][15:11] == 5'd0) return j + 1;
    end
    return lim;
  endfunction

  task automatic sample(input int i, output logic [31:0] a, output logic [31:0] op,
                        output logic [31:0] opd, output logic [31:0] r, output logic [31:0] h,
                        output logic [31:0] d, output logic [31:0] ov, output logic [31:0] c);
    case (i)
      0: begin a = 32'(addr_a); op = 32'(op_a); opd = 32'(opd_a); r = 32'(run_a);
               h = 32'(hlt_a); d = 32'(dn_a); ov = 32'(ovf_a); c = 32'(cnt_a); end
      1: begin a = 32'(addr_b); op = 32'(op_b); opd = 32'(opd_b); r = 32'(run_b);
               h = 32'(hlt_b); d = 32'(dn_b); ov = 32'(ovf_b); c = 32'(cnt_b); end
      default: begin a = 32'(addr_c); op = 32'(op_c); opd = 32'(opd_c); r = 32'(run_c);
               h = 32'(hlt_c); d = 32'(dn_c); ov = 32'(ovf_c); c = 32'(cnt_c); end
    endcase
  endtask

  task automatic check_idle(input string tag);
    logic [31:0] a, op, opd, r, h, d, ov, c;
    for (int i = 0; i < N; i++) begin
      sample(i, a, op, opd, r, h, d, ov, c);
      check($sformatf("%s_addr[%0d]", tag, i), a, 0);
      check($sformatf("%s_opcode[%0d]", tag, i), op, 0);
      check($sformatf("%s_operand[%0d]", tag, i), opd, 0);
      check($sformatf("%s_running[%0d]", tag, i), r, 0);
      check($sformatf("%s_halted[%0d]", tag, i), h, 0);
      check($sformatf("%s_done[%0d]", tag, i), d, 0);
      check($sformatf("%s_ovf[%0d]", tag, i), ov, 0);
      check($sformatf("%s_count[%0d]", tag, i), c, 0);
    end
  endtask

  task automatic load_program(input int halt_at);
    for (int j = 0; j < 2048; j++) mem[j] = {5'($urandom_range(1, 31)), 11'($urandom)};
    if (halt_at >= 0) mem[halt_at] = {5'd0, 11'($urandom)};
  endtask

  // step_mode: 0 = every cycle executes, 1 = random step, 2 = step every 4th cycle.
  task automatic run_program(input int step_mode, input bit poke_start);
    int e[N]; int len[N]; int hc[N]; bit ovf[N];
    int cyc; bit all_run; bit finished; bit ex; int min_hc;
    logic [31:0] a, op, opd, r, h, d, ov, c;
    logic [15:0] w;
    for (int i = 0; i < N; i++) begin
      e[i]   = 0;
      hc[i]  = 0;
      len[i] = run_len(i);
      ovf[i] = (len[i] == (1 << pcw(i))) && (mem[len[i]-1][15:11] != 5'd0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    finished = 1'b0;
    while (!finished && cyc < 5000) begin
      all_run = 1'b1;
      for (int i = 0; i < N; i++) if (e[i] >= len[i]) all_run = 1'b0;
      if (!STEP_EN || step_mode == 0) step_v = 1'b1;
      else if (step_mode == 1)        step_v = ($urandom_range(0, 2) == 0);
      else                            step_v = ((cyc % 4) == 3);
      ex = step_v;
      start = poke_start && all_run && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        sample(i, a, op, opd, r, h, d, ov, c);
        if (e[i] < len[i]) begin
          w = mem[e[i]];
          check($sformatf("run_running[%0d]", i), r, 1);
          check($sformatf("run_halted[%0d]", i), h, 0);
          check($sformatf("run_done[%0d]", i), d, 0);
          check($sformatf("run_addr[%0d]", i), a, e[i]);
          check($sformatf("run_count[%0d]", i), c, sat(i, e[i]));
          check($sformatf("run_ovf[%0d]", i), ov, 0);
          check($sformatf("run_opcode[%0d]", i), op, ex ? 32'(w[15:11]) : 0);
          check($sformatf("run_operand[%0d]", i), opd, ex ? 32'(w[10:0]) : 0);
          if (ex) e[i]++;
        end else begin
          check($sformatf("halt_running[%0d]", i), r, 0);
          check($sformatf("halt_halted[%0d]", i), h, 1);
          check($sformatf("halt_done[%0d]", i), d, (hc[i] == 0) ? 1 : 0);
          check($sformatf("halt_addr[%0d]", i), a, len[i] - 1);
          check($sformatf("halt_count[%0d]", i), c, sat(i, len[i]));
          check($sformatf("halt_ovf[%0d]", i), ov, ovf[i]);
          check($sformatf("halt_opcode[%0d]", i), op, 0);
          check($sformatf("halt_operand[%0d]", i), opd, 0);
          hc[i]++;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      finished = 1'b1;
      for (int i = 0; i < N; i++) if (hc[i] < 3) finished = 1'b0;
    end
    min_hc = hc[0];
    for (int i = 1; i < N; i++) if (hc[i] < min_hc) min_hc = hc[i];
    check("run_reached_halt", (min_hc >= 3) ? 1 : 0, 1);
  endtask

  initial begin
    logic [31:0] a, op, opd, r, h, d, ov, c;
    rst_n  = 1'b0;
    start  = 1'b0;
    step_v = 1'b0;
    load_program(3);

    // Reset, then idle with start low.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_idle("idle");
    end
    @(posedge clk); #1;

    // Straight-line program: LDI 5, ADDI 3, STO 2, HALT.
    load_program(3);
    mem[0] = {5'd3, 11'd5};
    mem[1] = {5'd5, 11'd3};
    mem[2] = {5'd1, 11'd2};
    run_program(0, 1'b0);
    // Restart from HALT with the same program.
    run_program(0, 1'b0);

    // Random programs: HALT early, late (small instances overflow) and mid-run start pokes.
    for (int k = 0; k < 14; k++) begin
      if ($urandom_range(0, 2) == 0) load_program($urandom_range(16, 40));
      else                           load_program($urandom_range(0, 20));
      run_program(0, ($urandom_range(0, 1) == 1));
    end

    // No HALT anywhere: every instance runs off the end of its memory.
    load_program(-1);
    run_program(0, 1'b0);
    // Overflow flag clears on the next start.
    load_program(2);
    run_program(0, 1'b0);

    // Reset mid-run at PC = 2.
    load_program(10);
    step_v = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sample(0, a, op, opd, r, h, d, ov, c);
    check("midrun_addr_before_reset", a, 2);
    check("midrun_count_before_reset", c, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk); #1;

`ifdef BIP_STEP_MODE_EN
    // Three-instruction program stepped every 4th cycle, then random stepping.
    load_program(2);
    mem[0] = {5'd3, 11'd7};
    mem[1] = {5'd5, 11'd1};
    run_program(2, 1'b0);
    for (int k = 0; k < 6; k++) begin
      load_program($urandom_range(0, 20));
      run_program(1, ($urandom_range(0, 1) == 1));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
